prco_mem_arbiter: RTL

- Shares the single-port on-chip local memory between two requesters: the instruction fetch port (read-only) and the data port (LW/SW from the ALU stage).
- Arbitrates between the two, registers the winning address/write data, and drives the memory enable, write-enable, address and write-data lines.
- Waits a fixed read latency, then returns read data with a one-cycle done pulse to the granted requester.
- Sits between the pipeline control and local memory; it replaces direct fetch/ALU clock-enables into memory.

---
 rtl/prco_mem_arbiter_pkg.sv | 28 ++
 rtl/prco_mem_arbiter_pick.sv | 40 ++++
 rtl/prco_mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/prco_mem_arbiter_pkg.sv
// prco_mem_arbiter_pkg
//   Shared constants for the local-memory arbiter slice:
//   - REG_WIDTH and the data/address width defaults derived from it
//   - FSM state encodings (S_IDLE / S_ACCESS / S_WAIT)
//   - requester index constants used in the req/done vectors
//   - cnt_width(): counter width able to hold a value, minimum 2 bits
package prco_mem_arbiter_pkg;

    localparam int REG_WIDTH  = 16;
    localparam int DEF_DATA_W = REG_WIDTH;
    localparam int DEF_ADDR_W = REG_WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    // Bit positions inside the {data, fetch} request/done vectors
    localparam int PORT_F = 0;
    localparam int PORT_D = 1;

    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 2) w = 2;
        return w;
    endfunction

endpackage

// File: rtl/prco_mem_arbiter_pick.sv
// prco_mem_arb_pick
//   Combinational grant selector for the memory arbiter.
//   Ports:
//     req[1:0]     request vector, index PORT_F = fetch, PORT_D = data
//     done[1:0]    done pulses currently on the outputs, same indexing
//     starve_cnt   consecutive data grants taken while fetch was waiting
//     grant_f      fetch wins this cycle
//     grant_d      data wins this cycle
//   The winner is chosen from the raw requests (data first, unless fetch
//   has been passed over P_STARVE_MAX times). If that winner is the
//   requester whose done pulse is showing, nobody is granted this cycle:
//   its req may simply not have dropped yet, and promoting the other port
//   instead would break the priority order for requesters that keep req
//   high for back-to-back accesses.
module prco_mem_arb_pick
    import prco_mem_arbiter_pkg::*;
#(
    parameter int P_STARVE_MAX = 3,
    parameter int P_CNT_W      = 2
) (
    input  logic [1:0]         req,
    input  logic [1:0]         done,
    input  logic [P_CNT_W-1:0] starve_cnt,
    output logic               grant_f,
    output logic               grant_d
);

    logic force_f;
    logic win_f;
    logic win_d;

    always_comb begin
        force_f = req[PORT_F] && (starve_cnt == P_CNT_W'(P_STARVE_MAX));
        win_f   = req[PORT_F] && (!req[PORT_D] || force_f);
        win_d   = req[PORT_D] && !win_f;
        grant_f = win_f && !done[PORT_F];
        grant_d = win_d && !done[PORT_D];
    end

endmodule

// File: rtl/prco_mem_arbiter.sv
// prco_mem_arbiter
//   Shares the single-port local memory between instruction fetch
//   (read-only) and the data port (loads/stores).
//   Ports:
//     i_clk, i_reset            clock, asynchronous active-high reset
//     i_f_req, i_f_addr         fetch request / address
//     q_f_done, q_f_rdata       fetch done pulse / fetched word
//     i_d_req, i_d_we           data request / 1 = store, 0 = load
//     i_d_addr, i_d_wdata       data address / store data
//     q_d_done, q_d_rdata       data done pulse / load result
//     q_mem_ce, q_mem_we        memory enable / write enable (with ce)
//     q_mem_addr, q_mem_dina    registered memory address / write data
//     i_mem_douta               memory read data
//     q_busy                    high whenever the FSM is not idle
//
//   Handshake: a requester raises req with stable addr/we/wdata and holds
//   it until its done pulse. Fields are sampled only in the cycle the
//   request is granted. Done is a one-cycle pulse seen in the first idle
//   cycle after the access; during that cycle the same requester's req is
//   ignored, so it may drop req one cycle late without a second grant.
//
//   Sequence per access: S_IDLE (grant, register fields) -> S_ACCESS (ce
//   high for one cycle) -> S_WAIT (P_MEM_LATENCY cycles; read data is
//   captured in the last one) -> S_IDLE with done.
module prco_mem_arbiter
    import prco_mem_arbiter_pkg::*;
#(
    parameter int P_ADDR_W       = DEF_ADDR_W,
    parameter int P_DATA_W       = DEF_DATA_W,
    parameter int P_MEM_LATENCY  = 1,
    parameter int P_FETCH_STARVE = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_f_req,
    input  logic [P_ADDR_W-1:0] i_f_addr,
    output logic                q_f_done,
    output logic [P_DATA_W-1:0] q_f_rdata,
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [P_ADDR_W-1:0] i_d_addr,
    input  logic [P_DATA_W-1:0] i_d_wdata,
    output logic                q_d_done,
    output logic [P_DATA_W-1:0] q_d_rdata,
    output logic                q_mem_ce,
    output logic                q_mem_we,
    output logic [P_ADDR_W-1:0] q_mem_addr,
    output logic [P_DATA_W-1:0] q_mem_dina,
    input  logic [P_DATA_W-1:0] i_mem_douta,
    output logic                q_busy
);

    localparam int LAT_W = cnt_width(P_MEM_LATENCY);
    localparam int SW    = cnt_width(P_FETCH_STARVE);

    logic [1:0]       state;
    logic [LAT_W-1:0] lat_cnt;
    logic [SW-1:0]    starve_cnt;
    logic             sel_d;      // current access belongs to the data port
    logic             sel_load;   // current data access is a load
    logic             grant_f;
    logic             grant_d;

    prco_mem_arb_pick #(
        .P_STARVE_MAX (P_FETCH_STARVE),
        .P_CNT_W      (SW)
    ) u_pick (
        .req        ({i_d_req, i_f_req}),
        .done       ({q_d_done, q_f_done}),
        .starve_cnt (starve_cnt),
        .grant_f    (grant_f),
        .grant_d    (grant_d)
    );

    assign q_busy = (state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            sel_d      <= 1'b0;
            sel_load   <= 1'b0;
            q_f_done   <= 1'b0;
            q_f_rdata  <= '0;
            q_d_done   <= 1'b0;
            q_d_rdata  <= '0;
            q_mem_ce   <= 1'b0;
            q_mem_we   <= 1'b0;
            q_mem_addr <= '0;
            q_mem_dina <= '0;
        end else begin
            // Done flags are pulses: only the S_WAIT exit raises them.
            q_f_done <= 1'b0;
            q_d_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant_f || grant_d) begin
                        state      <= S_ACCESS;
                        q_mem_ce   <= 1'b1;
                        q_mem_we   <= grant_d && i_d_we;
                        q_mem_addr <= grant_d ? i_d_addr : i_f_addr;
                        sel_d      <= grant_d;
                        sel_load   <= grant_d && !i_d_we;
                        if (grant_d) begin
                            q_mem_dina <= i_d_wdata;
                        end
                    end

                    // Starvation count: data grants taken while fetch waits.
                    if (!i_f_req || grant_f) begin
                        starve_cnt <= '0;
                    end else if (grant_d && (starve_cnt != SW'(P_FETCH_STARVE))) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end

                S_ACCESS: begin
                    q_mem_ce <= 1'b0;
                    q_mem_we <= 1'b0;
                    lat_cnt  <= LAT_W'(P_MEM_LATENCY);
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        lat_cnt <= '0;
                        state   <= S_IDLE;
                        if (sel_d) begin
                            q_d_done <= 1'b1;
                            if (sel_load) begin
                                q_d_rdata <= i_mem_douta;
                            end
                        end else begin
                            q_f_done  <= 1'b1;
                            q_f_rdata <= i_mem_douta;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    q_mem_ce <= 1'b0;
                    q_mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
